// File: rtl/mult_seq_sm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_sm_if
//  Description : Operand/result bundle for the sequential sign-magnitude
//                multiplier (request side and product side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_seq_sm_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         overflow;

    modport master (
        output start, a, b,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, overflow
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq_sm.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_sm
//  Description : Shift-add sign-magnitude Q-format multiplier, one multiplier
//                bit per cycle, saturating truncated product with done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_sm #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      local_reset,
    mult_seq_sm_if.slave   bus
);

    localparam int            c_AW   = 2 * N - 2;
    localparam int            c_CW   = $clog2(N - 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-2:0]      r_ma;
    logic [N-2:0]      r_mb;
    logic              r_s;
    logic [c_AW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [N-1:0]      r_product;
    logic              r_overflow;
    logic              r_done;

    logic [c_AW-1:0]   w_addend;
    logic              w_ovf;
    logic [N-2:0]      w_mag;
    logic              w_sign;

    // Next-state logic; the synchronous clear overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (local_reset) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Partial product and the saturating, sign-corrected result.
    always_comb begin
        w_addend = {{(N-1){1'b0}}, r_ma} << r_cnt;
        w_ovf    = |r_acc[c_AW-1:N-1+Q];
        w_mag    = w_ovf ? {(N-1){1'b1}} : r_acc[N-2+Q:Q];
        w_sign   = r_s & (|w_mag);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ma       <= '0;
            r_mb       <= '0;
            r_s        <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (local_reset) begin
                r_product  <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_ma  <= bus.a[N-2:0];
                            r_mb  <= bus.b[N-2:0];
                            r_s   <= bus.a[N-1] ^ bus.b[N-1];
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                    end
                    S_CALC: begin
                        if (r_mb[r_cnt]) begin
                            r_acc <= r_acc + w_addend;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_FIN: begin
                        r_product  <= {w_sign, w_mag};
                        r_overflow <= w_ovf;
                        r_done     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy     = (r_state == S_CALC) || (r_state == S_FIN);
    assign bus.done     = r_done;
    assign bus.product  = r_product;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_sm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq_sm
//  Description : Directed self-checking bench for mult_seq_sm (Q16.16, N=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_sm;

    logic clk;
    logic reset;
    logic local_reset;
    int   checks;
    int   failures;

    mult_seq_sm_if #(.N(32)) bus ();

    mult_seq_sm #(.Q(16), .N(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .local_reset (local_reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one operation; report done latency, first result, done count, busy shape.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                         output int lat, output logic [31:0] p, output logic o,
                         output int dcnt, output logic busy_ok);
        @(negedge clk);
        bus.a = ia; bus.b = ib; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_ok = (bus.busy === 1'b1);
        lat = -1; dcnt = 0; p = 'x; o = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dcnt++;
                if (lat < 0) begin lat = k; p = bus.product; o = bus.overflow; end
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else if (lat < 0 && bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; local_reset = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL reset_product got=%h exp=%h", bus.product, 32'h0); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h00018000, 32'h00020000, lat, p, o, dcnt, bok);
        checks++; if (lat !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", lat); end
        checks++; if (p !== 32'h00030000) begin failures++; $display("FAIL basic_product got=%h exp=00030000", p); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", o); end
        checks++; if (dcnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dcnt); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy_shape got=%b exp=1", bok); end
    endtask

    task automatic test_sign;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h80018000, 32'h00020000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h80030000) begin failures++; $display("FAIL sign_neg_pos got=%h exp=80030000", p); end
        do_op(32'h80018000, 32'h80020000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h00030000) begin failures++; $display("FAIL sign_neg_neg got=%h exp=00030000", p); end
        checks++; if (lat !== 32) begin failures++; $display("FAIL sign_latency got=%0d exp=32", lat); end
    endtask

    task automatic test_negzero;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h80000001, 32'h00000001, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h00000000) begin failures++; $display("FAIL negzero_product got=%h exp=00000000", p); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL negzero_overflow got=%b exp=0", o); end
    endtask

    task automatic test_truncation;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        // 0.5 * 0.5 = 0.25
        do_op(32'h00008000, 32'h00008000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h00004000) begin failures++; $display("FAIL frac_product got=%h exp=00004000", p); end
        // 0x3 * 0x5555 raw = 0xFFFF, truncates to zero
        do_op(32'h00000003, 32'h80005555, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h00000000) begin failures++; $display("FAIL trunc_product got=%h exp=00000000", p); end
        // 1.0 * 32767.0 sits just below the overflow range
        do_op(32'h00010000, 32'h7FFF0000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h7FFF0000) begin failures++; $display("FAIL maxrange_product got=%h exp=7fff0000", p); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL maxrange_overflow got=%b exp=0", o); end
    endtask

    task automatic test_saturation;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h01000000, 32'h01000000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_pos_product got=%h exp=7fffffff", p); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL sat_pos_overflow got=%b exp=1", o); end
        do_op(32'h81000000, 32'h01000000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_neg_product got=%h exp=ffffffff", p); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL sat_neg_overflow got=%b exp=1", o); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow_held got=%b exp=1", bus.overflow); end
        do_op(32'h00018000, 32'h00020000, lat, p, o, dcnt, bok);
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL sat_recover_overflow got=%b exp=0", o); end
        checks++; if (p !== 32'h00030000) begin failures++; $display("FAIL sat_recover_product got=%h exp=00030000", p); end
    endtask

    task automatic test_start_while_busy;
        int dcnt, lat; logic [31:0] p;
        dcnt = 0; lat = -1; p = 'x;
        @(negedge clk);
        bus.a = 32'h00018000; bus.b = 32'h00020000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin
                bus.a = 32'h00010000; bus.b = 32'h00010000; bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dcnt++;
                if (lat < 0) begin lat = k; p = bus.product; end
            end
        end
        checks++; if (dcnt !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dcnt); end
        checks++; if (lat !== 32) begin failures++; $display("FAIL busy_start_latency got=%0d exp=32", lat); end
        checks++; if (p !== 32'h00030000) begin failures++; $display("FAIL busy_start_product got=%h exp=00030000", p); end
    endtask

    task automatic test_back_to_back;
        int t_done[3]; int n; int t; logic both;
        n = 0; t = 0; both = 1'b0;
        @(negedge clk);
        bus.a = 32'h80018000; bus.b = 32'h00020000; bus.start = 1'b1;
        for (int k = 0; k < 150 && n < 3; k++) begin
            @(posedge clk); #1;
            t++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) both = 1'b1;
            if (bus.done === 1'b1) begin
                t_done[n] = t;
                n++;
                checks++; if (bus.product !== 32'h80030000) begin failures++; $display("FAIL b2b_product got=%h exp=80030000", bus.product); end
            end
        end
        bus.start = 1'b0;
        checks++; if (n !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", n); end
        if (n == 3) begin
            checks++; if (t_done[1] - t_done[0] !== 33) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=33", t_done[1] - t_done[0]); end
            checks++; if (t_done[2] - t_done[1] !== 33) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=33", t_done[2] - t_done[1]); end
        end
        checks++; if (both !== 1'b0) begin failures++; $display("FAIL b2b_busy_and_done got=%b exp=0", both); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_local_reset;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h01000000, 32'h01000000, lat, p, o, dcnt, bok);
        @(negedge clk);
        bus.a = 32'h00018000; bus.b = 32'h00020000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        local_reset = 1'b1;
        @(posedge clk); #1;
        local_reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL lclr_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL lclr_product got=%h exp=00000000", bus.product); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL lclr_overflow got=%b exp=0", bus.overflow); end
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL lclr_no_done got=%0d exp=0", dcnt); end
        // Clear and start together: the start is dropped.
        @(negedge clk);
        bus.start = 1'b1; local_reset = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; local_reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL lclr_start_busy got=%b exp=0", bus.busy); end
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL lclr_start_no_done got=%0d exp=0", dcnt); end
    endtask

    task automatic test_async_reset;
        int lat, dcnt; logic [31:0] p; logic o, bok;
        do_op(32'h81000000, 32'h01000000, lat, p, o, dcnt, bok);
        @(negedge clk);
        bus.a = 32'h00018000; bus.b = 32'h00020000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL areset_product got=%h exp=00000000", bus.product); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL areset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL areset_no_done got=%0d exp=0", dcnt); end
        do_op(32'h00018000, 32'h00020000, lat, p, o, dcnt, bok);
        checks++; if (p !== 32'h00030000) begin failures++; $display("FAIL areset_recover_product got=%h exp=00030000", p); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_sign();
        test_negzero();
        test_truncation();
        test_saturation();
        test_start_while_busy();
        test_back_to_back();
        test_local_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_seq_sm.md
# mult_seq_sm

Iterative sign-magnitude fixed-point multiplier for the convolution datapath. It sits directly upstream of the sequential accumulator. It multiplies one pixel and one weight per operation using shift-add, one multiplier bit per cycle. It presents a truncated Q-format product with a one-cycle `done` pulse that drives the accumulator's add-enable.

## Interface
Parameters:
- `Q`, 16: number of fractional bits.
- `N`, 32: total word width. Bit N-1 is the sign; bits N-2:0 are the magnitude.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `local_reset`  in  1  synchronous clear, active-high. Priority over all other inputs except `reset`.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  operand (pixel), sign-magnitude.
- `b`  in  N  operand (weight), sign-magnitude.
- `busy`  out  1  high in CALC and FIN.
- `done`  out  1  one-cycle pulse when `product` is valid.
- `product`  out  N  sign-magnitude result, held until the next result or clear.
- `overflow`  out  1  saturation flag for `product`, held alongside it.

## Operation
- States: IDLE, CALC, FIN.
- IDLE with `start`=1:
  - Latch `ma`=a[N-2:0] and `mb`=b[N-2:0].
  - Latch sign `s`=a[N-1]^b[N-1].
  - Clear the 2(N-1)-bit accumulator `acc`.
  - Set iteration counter to 0.
  - Go to CALC.
- CALC, one iteration per cycle for N-1 cycles:
  - If `mb`[cnt]=1, add `ma`<<cnt to `acc`.
  - After iteration N-2, go to FIN.
- FIN:
  - `mag` = acc[N-2+Q : Q]. Fraction bits below Q are truncated toward zero; there is no rounding.
  - If any bit of acc[2N-3 : N-1+Q] is set: `mag` = all ones (0x7FFFFFFF for N=32) and `overflow`=1. Otherwise `overflow`=0.
  - If `mag`=0, the sign is forced to 0 (no negative zero). Otherwise the sign is `s`.
  - Register `product` and `overflow`, pulse `done`, return to IDLE.
- `start` in CALC or FIN is ignored; there is no queueing.
- `a` and `b` are sampled only on the accepting edge and may change afterwards.
- `local_reset` or `reset` in any state:
  - state → IDLE; `product`, `overflow`, `done`, `busy` → 0.
  - The in-flight operation is discarded and never produces `done`.
- `local_reset` and `start` in the same cycle: the clear wins and `start` is dropped.

## Timing
- Reset values: `product`=0, `overflow`=0, `done`=0, `busy`=0, state IDLE.
- Let the edge that samples `start` be edge 0:
  - `busy` is high after edge 0.
  - Edges 1..N-1 perform the CALC iterations.
  - Edge N executes FIN: `product`/`overflow` update, `done`=1 for exactly one cycle, `busy`=0.
- Latency from the accepting edge to valid `done`/`product` is N cycles (32 at the default).
- The earliest next `start` is sampled at edge N+1, while `done` is high. Back-to-back throughput is one result per N+1 cycles.
- `done` is never high for two consecutive cycles.
- `product` and `overflow` stay stable from edge N until the next FIN or clear. This lets the accumulator sample `product` on the `done` cycle.
- `busy` and `done` are never high together.

## Test plan
- Positive case: reset, then `a`=0x00018000 (1.5), `b`=0x00020000 (2.0), one-cycle `start`.
  - Required: `done` exactly 32 edges after the accepting edge, `product`=0x00030000, `overflow`=0.
  - `busy` high for edges 0..31.
- Sign handling: `a`=0x80018000 (-1.5), `b`=0x00020000 → `product`=0x80030000. With `a`=0x80018000, `b`=0x80020000 → `product`=0x00030000.
- Negative-zero suppression: `a`=0x80000001, `b`=0x00000001. The true product truncates to zero, so `product`=0x00000000 (sign 0) and `overflow`=0.
- Saturation: `a`=0x01000000, `b`=0x01000000 (256×256) → `product`=0x7FFFFFFF, `overflow`=1. With `a`=0x81000000 → `product`=0xFFFFFFFF, `overflow`=1. A subsequent in-range multiply clears `overflow` at its FIN.
- Start while busy and back-to-back:
  - Pulse `start` again at edge 10 with different operands. It must be ignored: one `done`, with the first operation's result.
  - Then hold `start`=1 continuously. Successive `done` pulses must arrive exactly 33 cycles apart.
- Mid-operation clears:
  - Assert `local_reset` at edge 15 of an operation. Required: IDLE next cycle, `product`=0, no `done` ever for that operation.
  - Repeat with asynchronous `reset` asserted between clock edges. Outputs must clear immediately, without waiting for `clk`.
